// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtraction controller:
// FSM state encodings and the counter-width helper.
package serial_sub_ctrl_pkg;

    // Controller states. Encoding 2'd3 is never entered and is treated as IDLE.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Smallest n such that 2**n >= value. Used to size the bit counter so it
    // can index 0..WIDTH-1 without spare headroom.
    function automatic int clog2(input int unsigned value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if (value > (32'd1 << i)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_full_sub_bit.sv
// Combinational 1-bit full subtractor assembled from two half-subtractor
// stages; the two stage borrows are ORed into the borrow-out.
module full_sub_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    logic hs1_diff;
    logic hs1_borrow;
    logic hs2_borrow;

    // First half subtractor: a - b.
    always_comb begin
        hs1_diff   = a_i ^ b_i;
        hs1_borrow = ~a_i & b_i;
    end

    // Second half subtractor: (a - b) - bin, then merge the borrows.
    always_comb begin
        d_o        = hs1_diff ^ bin_i;
        hs2_borrow = ~hs1_diff & bin_i;
        bout_o     = hs1_borrow | hs2_borrow;
    end

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtraction controller. Processes one operand bit per clock,
// LSB first, through a single full_sub_bit cell and publishes the registered
// difference and final borrow with a one-cycle done pulse.
module serial_sub_ctrl
    import serial_sub_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int                CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    // Partial result holds only the upper WIDTH-1 bits already produced; the
    // bit computed in the final step is concatenated on when diff is loaded,
    // so no register bit is written that is never read.
    logic [WIDTH-2:0] res_q,    res_d;
    logic             bin_q,    bin_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;

    logic             cell_d;
    logic             cell_bout;
    logic [WIDTH-1:0] res_shift;

    // The one and only subtractor cell, fed by the operand LSBs and the
    // borrow chain register.
    full_sub_bit u_cell (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .bin_i  (bin_q),
        .d_o    (cell_d),
        .bout_o (cell_bout)
    );

    // New result bit enters from the MSB side; everything moves one place right.
    always_comb begin
        res_shift = {cell_d, res_q};
    end

    // Next-state logic for the sequencer and its datapath registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        bin_d    = bin_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            ST_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shift[WIDTH-1:1];
                bin_d = cell_bout;
                if (cnt_q == CNT_LAST) begin
                    diff_d   = res_shift;
                    borrow_d = cell_bout;
                    cnt_d    = '0;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                // IDLE and the unused encoding both wait for a request.
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    res_d   = '0;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            bin_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            bin_q    <= bin_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    // Status flags decode directly from state; results come from registers.
    always_comb begin
        busy   = (state_q == ST_RUN);
        done   = (state_q == ST_DONE);
        diff   = diff_q;
        borrow = borrow_q;
    end

endmodule
